// File: rtl/digdug_sprite_scanner_if.sv
// Scanner-side bus: scan control, SP attribute RAM read port and sprite list FIFO.
interface digdug_sprite_scanner_if;
  logic        SCAN_START;
  logic [7:0]  SCAN_LINE;
  logic [6:0]  SPATAD;
  logic [23:0] SPATDT;
  logic        LIST_RD;
  logic [30:0] LIST_DT;
  logic [4:0]  LIST_CNT;
  logic        SCAN_BUSY;
  logic        SCAN_OVF;

  modport master (
    output SCAN_START, SCAN_LINE, SPATDT, LIST_RD,
    input  SPATAD, LIST_DT, LIST_CNT, SCAN_BUSY, SCAN_OVF
  );

  modport slave (
    input  SCAN_START, SCAN_LINE, SPATDT, LIST_RD,
    output SPATAD, LIST_DT, LIST_CNT, SCAN_BUSY, SCAN_OVF
  );
endinterface

// File: rtl/digdug_sprite_scanner.sv
// Per-scanline sprite evaluator: walks the SP attribute RAM, tests each sprite against the
// current line and queues up to MAXSPR hits (index order) in a FWFT list FIFO.
module digdug_sprite_scanner #(
  parameter int unsigned NSPR   = 64,
  parameter int unsigned MAXSPR = 8,
  parameter logic [7:0]  YOFS   = 8'd16
) (
  input logic                     CL,
  input logic                     RESET,
  digdug_sprite_scanner_if.slave  bus
);
  localparam int unsigned PW = (MAXSPR > 1) ? $clog2(MAXSPR) : 1;
  localparam int unsigned CW = 5;
  localparam logic [5:0]  LAST = 6'(NSPR - 1);

  typedef struct packed {
    logic [7:0] code;
    logic [5:0] color;
    logic [8:0] x;
    logic [4:0] dy;
    logic       size;
    logic       flipx;
    logic       flipy;
  } entry_t;

  typedef struct packed {
    logic       dis;
    logic       size;
    logic       flipy;
    logic       flipx;
    logic [7:0] y;
    logic [7:0] code;
  } w0_t;

  typedef enum logic [1:0] {S_IDLE, S_A0, S_A1, S_EV} state_t;

  state_t        state, state_nx;
  logic [5:0]    spr, spr_nx;
  logic [CW-1:0] pushes, pushes_nx;
  logic [7:0]    line_r, line_nx;
  w0_t           w0_r, w0_nx;
  logic [6:0]    spatad_r, spatad_nx;
  logic          busy_r, busy_nx;
  logic          ovf_r, ovf_nx;
  logic          flush, push, pop;

  logic [7:0]    d;
  logic          hit;
  logic [4:0]    dy;
  entry_t        ent;

  entry_t        mem [MAXSPR];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          unused_bits;

  assign unused_bits = ^bus.SPATDT[22:19];

  // Hit test on latched w0 plus w1 arriving on the read port during EV
  always_comb begin
    d   = line_r + YOFS - w0_r.y;
    hit = !w0_r.dis && (d < (w0_r.size ? 8'd32 : 8'd16));
    dy  = w0_r.flipy ? ((w0_r.size ? 5'd31 : 5'd15) - d[4:0]) : d[4:0];
    ent = '{code:  w0_r.code,
            color: bus.SPATDT[5:0],
            x:     {bus.SPATDT[16], bus.SPATDT[15:8]},
            dy:    dy,
            size:  w0_r.size,
            flipx: w0_r.flipx,
            flipy: w0_r.flipy};
  end

  always_comb begin
    state_nx  = state;
    spr_nx    = spr;
    pushes_nx = pushes;
    line_nx   = line_r;
    w0_nx     = w0_r;
    spatad_nx = spatad_r;
    busy_nx   = busy_r;
    ovf_nx    = ovf_r;
    flush     = 1'b0;
    push      = 1'b0;
    if (bus.SCAN_START) begin
      flush     = 1'b1;
      line_nx   = bus.SCAN_LINE;
      spr_nx    = 6'd0;
      pushes_nx = '0;
      ovf_nx    = 1'b0;
      busy_nx   = 1'b1;
      spatad_nx = 7'd0;
      state_nx  = S_A0;
    end else begin
      unique case (state)
        S_IDLE: busy_nx = 1'b0;
        S_A0: begin
          spatad_nx = {spr, 1'b1};
          state_nx  = S_A1;
        end
        S_A1: begin
          w0_nx    = '{dis:   bus.SPATDT[23],
                       size:  bus.SPATDT[18],
                       flipy: bus.SPATDT[17],
                       flipx: bus.SPATDT[16],
                       y:     bus.SPATDT[15:8],
                       code:  bus.SPATDT[7:0]};
          state_nx = S_EV;
        end
        S_EV: begin
          // A hit beyond the per-scan budget ends the scan without reading further sprites
          if (hit && (pushes == CW'(MAXSPR))) begin
            ovf_nx   = 1'b1;
            busy_nx  = 1'b0;
            state_nx = S_IDLE;
          end else begin
            if (hit) begin
              push      = 1'b1;
              pushes_nx = pushes + 5'd1;
            end
            if (spr == LAST) begin
              busy_nx  = 1'b0;
              state_nx = S_IDLE;
            end else begin
              spr_nx    = spr + 6'd1;
              spatad_nx = {spr + 6'd1, 1'b0};
              state_nx  = S_A0;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      spr      <= 6'd0;
      pushes   <= '0;
      line_r   <= 8'd0;
      w0_r     <= '0;
      spatad_r <= 7'd0;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      spr      <= spr_nx;
      pushes   <= pushes_nx;
      line_r   <= line_nx;
      w0_r     <= w0_nx;
      spatad_r <= spatad_nx;
      busy_r   <= busy_nx;
      ovf_r    <= ovf_nx;
    end
  end

  // List FIFO; a flush wins over any same-cycle pop
  assign pop = bus.LIST_RD && (cnt != '0) && !flush;

  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CL) begin
    if (push) mem[wr_ptr] <= ent;
  end

  assign bus.SPATAD    = spatad_r;
  assign bus.LIST_CNT  = cnt;
  assign bus.LIST_DT   = (cnt != '0) ? mem[rd_ptr] : '0;
  assign bus.SCAN_BUSY = busy_r;
  assign bus.SCAN_OVF  = ovf_r;
endmodule
